// File: rtl/video_pattern_gen_if.sv
// Video stream bundle: vs/hs/de timing, 8-bit RGB and start-of-frame.
// The generator drives it through the master modport. Sinks use the slave modport.
interface video_pattern_gen_if;
    logic       vs_out;
    logic       hs_out;
    logic       de_out;
    logic [7:0] r_out;
    logic [7:0] g_out;
    logic [7:0] b_out;
    logic       sof_out;

    modport master (
        output vs_out, hs_out, de_out, r_out, g_out, b_out, sof_out
    );

    modport slave (
        input  vs_out, hs_out, de_out, r_out, g_out, b_out, sof_out
    );
endinterface

// File: rtl/video_pattern_gen.sv
// video_pattern_gen: raster timing generator with selectable test patterns.
// Patterns: 0 colour bars, 1 grey ramp, 2 checkerboard, 3 solid colour.
// Each output comes from one register stage. Outputs on cycle n+1 reflect
// the counters on cycle n. While en=0 the counters stay at (0,0), so raising
// en starts a frame at pixel (0,0).
// Optional build macro VIDEO_PATTERN_GEN_MOTION_EN adds an 8-bit per-frame
// offset that scrolls the ramp and checker patterns. It does not change the timing outputs.
module video_pattern_gen #(
    parameter int H_ACTIVE  = 1920,
    parameter int H_FP      = 88,
    parameter int H_SYNC    = 44,
    parameter int H_BP      = 148,
    parameter int V_ACTIVE  = 1080,
    parameter int V_FP      = 4,
    parameter int V_SYNC    = 5,
    parameter int V_BP      = 36,
    parameter int HS_POL    = 1,
    parameter int VS_POL    = 1,
    parameter int CELL_LOG2 = 5
) (
    input  logic                     pix_clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [1:0]               pattern_sel,
    input  logic [23:0]              solid_rgb,
    video_pattern_gen_if.master      vid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BW      = H_ACTIVE / 8;
    // Width of the pattern x position: wide enough for the 8-bit ramp and the checker bit.
    localparam int PW      = (CELL_LOG2 + 1 > 8) ? CELL_LOG2 + 1 : 8;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          HS_ACT   = (HS_POL != 0);
    localparam logic          VS_ACT   = (VS_POL != 0);

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_RAMP  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_SOLID = 2'd3
    } pattern_t;

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    pattern_t      pat_q, pat_d;
    logic [23:0]   solid_q, solid_d;
    logic          vs_q, vs_d;
    logic          hs_q, hs_d;
    logic          de_q, de_d;
    logic          sof_q, sof_d;
    logic [23:0]   rgb_q, rgb_d;

    logic          frame_start;
    logic          de_now;
    logic          hs_now;
    logic          vs_now;
    pattern_t      pat_eff;
    logic [23:0]   solid_eff;
    logic [2:0]    bar_idx;
    logic [23:0]   bar_rgb;
    logic [23:0]   pix_rgb;
    logic [PW-1:0] h_pos;
    logic          chk_bit;

    assign frame_start = en && (h_cnt_q == '0) && (v_cnt_q == '0);
    assign de_now      = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
    assign hs_now      = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
    assign vs_now      = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);

    // Pixel (0,0) already uses the newly sampled selection, so a new pattern
    // applies to the whole frame.
    assign pat_eff     = frame_start ? pattern_t'(pattern_sel) : pat_q;
    assign solid_eff   = frame_start ? solid_rgb : solid_q;

`ifdef VIDEO_PATTERN_GEN_MOTION_EN
    logic [7:0] offset_q, offset_d;

    // Offset advances once per frame start, so the offset used by pixel (0,0) of frame k is k.
    always_comb begin
        offset_d = offset_q;
        if (frame_start) begin
            offset_d = offset_q + 8'd1;
        end
    end

    // Offset register
    always_ff @(posedge pix_clk) begin
        if (rst) begin
            offset_q <= 8'd0;
        end else begin
            offset_q <= offset_d;
        end
    end

    assign h_pos = PW'(h_cnt_q) + PW'(offset_q);
`else
    assign h_pos = PW'(h_cnt_q);
`endif

    assign chk_bit = h_pos[CELL_LOG2] ^ v_cnt_q[CELL_LOG2];

    // Bar index from a compare chain. The last bar absorbs the remainder of H_ACTIVE/8.
    always_comb begin
        bar_idx = 3'd7;
        for (int i = 6; i >= 0; i--) begin
            if (h_cnt_q < HW'((i + 1) * BW)) begin
                bar_idx = 3'(i);
            end
        end
    end

    // Bar colour lookup
    always_comb begin
        bar_rgb = 24'h000000;
        case (bar_idx)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end

    // Pattern multiplexer
    always_comb begin
        pix_rgb = 24'h000000;
        case (pat_eff)
            PAT_BARS:  pix_rgb = bar_rgb;
            PAT_RAMP:  pix_rgb = {3{h_pos[7:0]}};
            PAT_CHECK: pix_rgb = chk_bit ? 24'hFFFFFF : 24'h000000;
            PAT_SOLID: pix_rgb = solid_eff;
            default:   pix_rgb = 24'h000000;
        endcase
    end

    // Next state: counters, shadow registers and the output stage. en=0 forces idle.
    always_comb begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        pat_d   = pat_q;
        solid_d = solid_q;
        de_d    = 1'b0;
        sof_d   = 1'b0;
        rgb_d   = 24'h000000;
        hs_d    = ~HS_ACT;
        vs_d    = ~VS_ACT;
        if (en) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
                v_cnt_d = v_cnt_q;
            end
            if (frame_start) begin
                pat_d   = pattern_t'(pattern_sel);
                solid_d = solid_rgb;
            end
            de_d  = de_now;
            sof_d = frame_start;
            rgb_d = de_now ? pix_rgb : 24'h000000;
            hs_d  = hs_now ? HS_ACT : ~HS_ACT;
            vs_d  = vs_now ? VS_ACT : ~VS_ACT;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge pix_clk) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            pat_q   <= PAT_BARS;
            solid_q <= 24'h000000;
            de_q    <= 1'b0;
            sof_q   <= 1'b0;
            rgb_q   <= 24'h000000;
            hs_q    <= ~HS_ACT;
            vs_q    <= ~VS_ACT;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            pat_q   <= pat_d;
            solid_q <= solid_d;
            de_q    <= de_d;
            sof_q   <= sof_d;
            rgb_q   <= rgb_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
        end
    end

    assign vid.vs_out  = vs_q;
    assign vid.hs_out  = hs_q;
    assign vid.de_out  = de_q;
    assign vid.sof_out = sof_q;
    assign vid.r_out   = rgb_q[23:16];
    assign vid.g_out   = rgb_q[15:8];
    assign vid.b_out   = rgb_q[7:0];

endmodule
